mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the 5-stage pipelined RISC-V core.
- Consumes the EX/MEM register outputs and resolves branches: PCSrc and target go back to IF.
- Performs word loads/stores into an internal data memory and one memory-mapped LED register.
- Registers the result into MEM/WB and presents the final write-back data to the register file.

Parameters:
DMEM_DEPTH, 256, data memory depth in 32-bit words (power of two)
DMEM_AW, $clog2(DMEM_DEPTH), word-index width (derived, not overridden)
LED_ADDR, 32'h0000_0400, byte address of the LED MMIO register

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous, active-low reset
alu_result_EX_MEM  in  32  load/store byte address, or ALU result
read_data2_EX_MEM  in  32  store data
add_alu_out_EX_MEM  in  32  branch target
pc_out_EX_MEM  in  32  PC of instruction (pass-through)
z_flag_EX_MEM  in  1  ALU zero flag
branch_EX_MEM  in  1  branch instruction
memread_EX_MEM  in  1  load
memwrite_EX_MEM  in  1  store
memtoreg_EX_MEM  in  1  write-back selects memory data
regwrite_EX_MEM  in  1  register write enable
rd_EX_MEM  in  5  destination register
pcsrc  out  1  take branch (combinational)
branch_target  out  32  = add_alu_out_EX_MEM (combinational)
read_data_MEM_WB  out  32  registered load data
alu_result_MEM_WB  out  32  registered ALU result
pc_out_MEM_WB  out  32  registered PC
memtoreg_MEM_WB  out  1  registered control
regwrite_MEM_WB  out  1  registered control
rd_MEM_WB  out  5  registered destination
write_back_data  out  32  memtoreg_MEM_WB ? read_data_MEM_WB : alu_result_MEM_WB
led_out  out  16  LED register
misalign_err  out  1  sticky misaligned-access flag

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a rising edge): all MEM_WB outputs, led_out and misalign_err go to 0. Data memory contents are not reset.
- pcsrc = branch_EX_MEM & z_flag_EX_MEM. This is pure combinational with zero latency; no flush logic in this block.
- Decode:
  - aligned = (alu_result_EX_MEM[1:0]==0).
  - is_led = (alu_result_EX_MEM == LED_ADDR).
  - DMEM index = alu_result_EX_MEM[DMEM_AW+1:2]; upper address bits are ignored, so addresses wrap.
- Store (memwrite_EX_MEM=1, aligned):
  - If is_led, led_out <= read_data2[15:0] at the edge and DMEM is untouched.
  - Otherwise DMEM[index] <= read_data2 at the edge.
- Load (memread_EX_MEM=1, aligned):
  - Data is {16'b0, led_out} if is_led, else DMEM[index].
  - The read is combinational and captured into read_data_MEM_WB at the same edge.
  - A load in cycle N+1 of an address stored in cycle N returns the new data.
- Non-load cycles: read_data_MEM_WB <= 0.
- Misaligned access ((memread|memwrite) & !aligned):
  - The store is suppressed and load data is 0.
  - misalign_err <= 1 and stays set until reset.
  - regwrite still propagates.
- memread and memwrite both 1 is treated as a store; the captured read data is then 0.
- MEM/WB register:
  - alu_result, pc_out, memtoreg and rd pass through with 1-cycle latency.
  - regwrite_MEM_WB <= regwrite_EX_MEM & (rd_EX_MEM != 0), so x0 is never written.
- No stall or enable input: the register loads every cycle.
- Reset mid-operation: a store present during the reset edge is NOT performed, and the pipeline register is cleared.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN=32 and REG_AW=5.
  - LED_ADDR default.
  - A MEM/WB control bundle typedef {memtoreg, regwrite, rd}.
- One natural sub-module, data_mem: a DMEM_DEPTH x 32 array with synchronous write and asynchronous read, inferable as distributed RAM.
- The MMIO decode, branch logic and MEM/WB register stay in mem_wb_stage.

Test Plan:
1. Reset: drive reset_n=0 for 2 cycles with arbitrary inputs -> all MEM_WB outputs, led_out and misalign_err read 0.
2. Store then load:
   - Cycle 1: store addr 0x10, data 0xDEADBEEF.
   - Cycle 2: load addr 0x10 with memtoreg=1, rd=5.
   - Expect read_data_MEM_WB=0xDEADBEEF, write_back_data=0xDEADBEEF, regwrite_MEM_WB=1, rd_MEM_WB=5.
3. Wrap and MMIO:
   - Store 0x1234_ABCD to 0x400 -> led_out=0xABCD, DMEM[0] unchanged.
   - Load 0x400 -> 0x0000ABCD.
   - Store 0x11 to 0x404, then load 0x4 -> 0x11 (the same word via DMEM index 1).
4. Branch:
   - branch=1, z=1, add_alu_out=0x80 -> pcsrc=1, branch_target=0x80 in the same cycle.
   - branch=1, z=0 -> pcsrc=0.
5. Misaligned: store to 0x12 -> DMEM[4] unchanged, misalign_err=1 and still 1 after 10 idle cycles, cleared only by reset.
6. x0 guard and mid-reset:
   - regwrite=1, rd=0 -> regwrite_MEM_WB=0.
   - A store asserted during a reset_n=0 edge leaves the target word unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipelined RISC-V core.
// Imported by every pipeline stage and its memories.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [XLEN-1:0] LED_ADDR_DEFAULT = 32'h0000_0400;

    // Write-back control carried through the MEM/WB register.
    typedef struct packed {
        logic              memtoreg;
        logic              regwrite;
        logic [REG_AW-1:0] rd;
    } mem_wb_ctrl_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are deliberately not reset so the array maps onto distributed RAM.
module data_mem
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage (branch resolve, DMEM/LED access) plus the MEM/WB pipeline register.
// Drives the final write-back data toward the register file.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned      DMEM_DEPTH = 256,
    parameter logic [XLEN-1:0]  LED_ADDR   = LED_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [XLEN-1:0]   alu_result_EX_MEM,
    input  logic [XLEN-1:0]   read_data2_EX_MEM,
    input  logic [XLEN-1:0]   add_alu_out_EX_MEM,
    input  logic [XLEN-1:0]   pc_out_EX_MEM,
    input  logic              z_flag_EX_MEM,
    input  logic              branch_EX_MEM,
    input  logic              memread_EX_MEM,
    input  logic              memwrite_EX_MEM,
    input  logic              memtoreg_EX_MEM,
    input  logic              regwrite_EX_MEM,
    input  logic [REG_AW-1:0] rd_EX_MEM,
    output logic              pcsrc,
    output logic [XLEN-1:0]   branch_target,
    output logic [XLEN-1:0]   read_data_MEM_WB,
    output logic [XLEN-1:0]   alu_result_MEM_WB,
    output logic [XLEN-1:0]   pc_out_MEM_WB,
    output logic              memtoreg_MEM_WB,
    output logic              regwrite_MEM_WB,
    output logic [REG_AW-1:0] rd_MEM_WB,
    output logic [XLEN-1:0]   write_back_data,
    output logic [15:0]       led_out,
    output logic              misalign_err
);

    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

    logic               aligned;
    logic               is_led;
    logic               misaligned;
    logic               store_en;
    logic               load_en;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_idx;
    logic [XLEN-1:0]    dmem_rdata;
    logic [XLEN-1:0]    load_data;
    mem_wb_ctrl_t       ctrl_d;
    mem_wb_ctrl_t       ctrl_q;
    logic [XLEN-1:0]    read_data_q;
    logic [XLEN-1:0]    alu_result_q;
    logic [XLEN-1:0]    pc_out_q;
    logic [15:0]        led_q;
    logic               err_q;

    assign pcsrc         = branch_EX_MEM & z_flag_EX_MEM;
    assign branch_target = add_alu_out_EX_MEM;

    assign aligned    = is_word_aligned(alu_result_EX_MEM);
    assign is_led     = (alu_result_EX_MEM == LED_ADDR);
    assign misaligned = (memread_EX_MEM | memwrite_EX_MEM) & ~aligned;
    assign dmem_idx   = alu_result_EX_MEM[DMEM_AW+1:2];

    // A store seen on a reset edge is dropped; simultaneous read+write acts as a store.
    assign store_en = memwrite_EX_MEM & aligned & reset_n;
    assign load_en  = memread_EX_MEM & ~memwrite_EX_MEM & aligned;
    assign dmem_we  = store_en & ~is_led;

    data_mem #(
        .DEPTH (DMEM_DEPTH)
    ) u_data_mem (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (dmem_idx),
        .wdata (read_data2_EX_MEM),
        .rdata (dmem_rdata)
    );

    always_comb begin
        load_data = '0;
        if (load_en) begin
            load_data = is_led ? {16'h0000, led_q} : dmem_rdata;
        end
    end

    always_comb begin
        ctrl_d          = '0;
        ctrl_d.memtoreg = memtoreg_EX_MEM;
        ctrl_d.regwrite = regwrite_EX_MEM & (rd_EX_MEM != '0);
        ctrl_d.rd       = rd_EX_MEM;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q       <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            pc_out_q     <= '0;
            led_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            read_data_q  <= load_data;
            alu_result_q <= alu_result_EX_MEM;
            pc_out_q     <= pc_out_EX_MEM;
            if (store_en && is_led) begin
                led_q <= read_data2_EX_MEM[15:0];
            end
            if (misaligned) begin
                err_q <= 1'b1;
            end
        end
    end

    assign read_data_MEM_WB  = read_data_q;
    assign alu_result_MEM_WB = alu_result_q;
    assign pc_out_MEM_WB     = pc_out_q;
    assign memtoreg_MEM_WB   = ctrl_q.memtoreg;
    assign regwrite_MEM_WB   = ctrl_q.regwrite;
    assign rd_MEM_WB         = ctrl_q.rd;
    assign write_back_data   = ctrl_q.memtoreg ? read_data_q : alu_result_q;
    assign led_out           = led_q;
    assign misalign_err      = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a reference model pushes expected MEM/WB
// contents when each cycle is driven; they are popped and compared after the edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] alu_result_EX_MEM;
    logic [31:0] read_data2_EX_MEM;
    logic [31:0] add_alu_out_EX_MEM;
    logic [31:0] pc_out_EX_MEM;
    logic        z_flag_EX_MEM;
    logic        branch_EX_MEM;
    logic        memread_EX_MEM;
    logic        memwrite_EX_MEM;
    logic        memtoreg_EX_MEM;
    logic        regwrite_EX_MEM;
    logic [4:0]  rd_EX_MEM;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic [31:0] read_data_MEM_WB;
    logic [31:0] alu_result_MEM_WB;
    logic [31:0] pc_out_MEM_WB;
    logic        memtoreg_MEM_WB;
    logic        regwrite_MEM_WB;
    logic [4:0]  rd_MEM_WB;
    logic [31:0] write_back_data;
    logic [15:0] led_out;
    logic        misalign_err;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .alu_result_EX_MEM  (alu_result_EX_MEM),
        .read_data2_EX_MEM  (read_data2_EX_MEM),
        .add_alu_out_EX_MEM (add_alu_out_EX_MEM),
        .pc_out_EX_MEM      (pc_out_EX_MEM),
        .z_flag_EX_MEM      (z_flag_EX_MEM),
        .branch_EX_MEM      (branch_EX_MEM),
        .memread_EX_MEM     (memread_EX_MEM),
        .memwrite_EX_MEM    (memwrite_EX_MEM),
        .memtoreg_EX_MEM    (memtoreg_EX_MEM),
        .regwrite_EX_MEM    (regwrite_EX_MEM),
        .rd_EX_MEM          (rd_EX_MEM),
        .pcsrc              (pcsrc),
        .branch_target      (branch_target),
        .read_data_MEM_WB   (read_data_MEM_WB),
        .alu_result_MEM_WB  (alu_result_MEM_WB),
        .pc_out_MEM_WB      (pc_out_MEM_WB),
        .memtoreg_MEM_WB    (memtoreg_MEM_WB),
        .regwrite_MEM_WB    (regwrite_MEM_WB),
        .rd_MEM_WB          (rd_MEM_WB),
        .write_back_data    (write_back_data),
        .led_out            (led_out),
        .misalign_err       (misalign_err)
    );

    typedef struct {
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [31:0] pc;
        logic        memtoreg;
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] wb;
        logic [15:0] led;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem_m [256];
    logic [15:0] led_m = '0;
    logic        err_m = 1'b0;
    logic [31:0] pc_cnt = 32'h0000_1000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One pipeline cycle: drive, check combinational branch outputs, model, clock, compare.
    task automatic step(input logic rst, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rd_en, input logic wr_en, input logic mtr, input logic rw,
                        input logic [4:0] rdd, input logic br, input logic z,
                        input logic [31:0] tgt, input string tag);
        exp_t        e;
        exp_t        g;
        logic        al;
        logic        led_hit;
        logic [7:0]  idx;
        reset_n            = rst;
        alu_result_EX_MEM  = addr;
        read_data2_EX_MEM  = wdata;
        add_alu_out_EX_MEM = tgt;
        pc_out_EX_MEM      = pc_cnt;
        z_flag_EX_MEM      = z;
        branch_EX_MEM      = br;
        memread_EX_MEM     = rd_en;
        memwrite_EX_MEM    = wr_en;
        memtoreg_EX_MEM    = mtr;
        regwrite_EX_MEM    = rw;
        rd_EX_MEM          = rdd;
        #1;
        check_eq({tag, ".pcsrc"}, {31'b0, pcsrc}, {31'b0, br & z});
        check_eq({tag, ".target"}, branch_target, tgt);

        al      = (addr[1:0] == 2'b00);
        led_hit = (addr == 32'h0000_0400);
        idx     = addr[9:2];
        if (!rst) begin
            e = '{default: '0};
            led_m = '0;
            err_m = 1'b0;
        end else begin
            e.read_data = '0;
            if (rd_en && !wr_en && al) e.read_data = led_hit ? {16'h0, led_m} : mem_m[idx];
            e.alu_result = addr;
            e.pc         = pc_cnt;
            e.memtoreg   = mtr;
            e.regwrite   = rw && (rdd != 5'd0);
            e.rd         = rdd;
            e.wb         = mtr ? e.read_data : addr;
            if (wr_en && al) begin
                if (led_hit) led_m = wdata[15:0];
                else         mem_m[idx] = wdata;
            end
            if ((rd_en || wr_en) && !al) err_m = 1'b1;
        end
        e.led = led_m;
        e.err = err_m;
        sb_q.push_back(e);
        pc_cnt += 32'd4;

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            g = sb_q.pop_front();
            check_eq({tag, ".read_data"}, read_data_MEM_WB, g.read_data);
            check_eq({tag, ".alu_result"}, alu_result_MEM_WB, g.alu_result);
            check_eq({tag, ".pc"}, pc_out_MEM_WB, g.pc);
            check_eq({tag, ".memtoreg"}, {31'b0, memtoreg_MEM_WB}, {31'b0, g.memtoreg});
            check_eq({tag, ".regwrite"}, {31'b0, regwrite_MEM_WB}, {31'b0, g.regwrite});
            check_eq({tag, ".rd"}, {27'b0, rd_MEM_WB}, {27'b0, g.rd});
            check_eq({tag, ".wb"}, write_back_data, g.wb);
            check_eq({tag, ".led"}, {16'b0, led_out}, {16'b0, g.led});
            check_eq({tag, ".err"}, {31'b0, misalign_err}, {31'b0, g.err});
        end
    endtask

    task automatic idle(input string tag);
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset with arbitrary activity, including a store that must be dropped.
        step(1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 32'h44, "rst0");
        step(1'b0, 32'h24, 32'h1111_2222, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 32'h48, "rst1");

        // Preload words that later reads depend on.
        step(1'b1, 32'h0, 32'hA5A5_0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, "pre0");
        step(1'b1, 32'h20, 32'h0202_0202, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, "pre20");

        // Store then immediately load.
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, "st10");
        step(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, "ld10");

        // LED MMIO and address wrap.
        step(1'b1, 32'h400, 32'h1234_ABCD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, "stled");
        step(1'b1, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0, "ldled");
        step(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0, "ld0");
        step(1'b1, 32'h404, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, "st404");
        step(1'b1, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0, "ld4");

        // Branch resolution.
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h80, "brtaken");
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h84, "brnot");

        // ALU result write-back and read+write collision.
        step(1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0, "alu");
        step(1'b1, 32'h8, 32'h0000_0055, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0, "rdwr");
        step(1'b1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0, "ld8");

        // Misaligned store: suppressed, sticky error.
        step(1'b1, 32'h12, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, "stmis");
        for (int i = 0; i < 10; i++) idle("idle");
        step(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, "ld10b");
        step(1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, "ldmis");

        // x0 guard.
        step(1'b1, 32'h99, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, "x0");

        // Store during reset edge is dropped; reset clears LED and error.
        step(1'b0, 32'h10, 32'h0BAD_0BAD, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0, "midrst");
        step(1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0, "ld10c");

        // Random ALU traffic and aligned store/load pairs.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [4:0]  r;
            a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if (a == 32'h400) a = 32'h3FC;
            d = $urandom;
            r = 5'($urandom_range(0, 31));
            step(1'b1, a, d, 1'b0, 1'b1, 1'b0, 1'b1, r, 1'b0, 1'b0, 32'h0, "rst");
            step(1'b1, a, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, r, 1'b0, 1'b0, 32'h0, "rld");
            step(1'b1, $urandom, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, r, 1'b1, 1'($urandom_range(0, 1)),
                 $urandom, "ralu");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
